spi_reg_bridge: RTL and testbench

Byte-level protocol engine between the SPI slave byte interface and the rest of the design. Consumes received bytes (`spi_rxdy` / `spi_data_o` from `SPI_slave`), decodes a command byte per SSEL frame, and performs burst writes into or reads from a 16 x 8 register bank with address auto-increment. Read data is supplied to the slave's transmit input (`spi_data_i`). All write activity is mirrored on a strobe port so downstream logic, such as the `fifo_mxn` write side, can track register updates.

---
 rtl/spi_reg_bridge.sv | 160 ++++++++++++++++
 tb/tb_spi_reg_bridge.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_bridge.sv
// Byte-level command engine behind an SPI slave: burst write/read of a 16 x 8 register bank.
// Outputs register on the edge that samples spi_rxdy; SSEL crosses a 2-flop synchronizer.
module spi_reg_bridge #(
    parameter logic [7:0] ID_VAL = 8'hA5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         SSEL,
    input  logic [7:0]   spi_data_o,
    input  logic         spi_rxdy,
    output logic [7:0]   spi_data_i,
    output logic         reg_wr,
    output logic [3:0]   reg_wr_addr,
    output logic [7:0]   reg_wr_data,
    output logic [127:0] reg_q,
    output logic         frame_err
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CMD  = 3'd1,
        WR   = 3'd2,
        RD   = 3'd3,
        DROP = 3'd4
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] addr, addr_nxt;
    logic [7:0] bank [0:14];

    logic       ssel_s1, ssel_s2, ssel_s3;
    logic       ssel_fall;

    logic [7:0] data_nxt;
    logic       wr_nxt;
    logic [3:0] wr_addr_nxt;
    logic [7:0] wr_data_nxt;
    logic       err_nxt;
    logic [3:0] cmd_addr;

    // Synchronizer resets to "selected" so a chip select held low through
    // reset does not look like a new frame; only a real falling edge starts one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ssel_s1 <= 1'b0;
            ssel_s2 <= 1'b0;
            ssel_s3 <= 1'b0;
        end else begin
            ssel_s1 <= SSEL;
            ssel_s2 <= ssel_s1;
            ssel_s3 <= ssel_s2;
        end
    end

    assign ssel_fall = ssel_s3 & ~ssel_s2;
    assign cmd_addr  = spi_data_o[3:0];

    genvar g;
    generate
        for (g = 0; g < 15; g++) begin : g_bank
            assign reg_q[g*8 +: 8] = bank[g];
        end
    endgenerate
    assign reg_q[127:120] = ID_VAL;

    always_comb begin
        state_nxt   = state;
        addr_nxt    = addr;
        data_nxt    = spi_data_i;
        wr_nxt      = 1'b0;
        wr_addr_nxt = reg_wr_addr;
        wr_data_nxt = reg_wr_data;
        err_nxt     = 1'b0;

        case (state)
            IDLE: begin
                if (ssel_fall)
                    state_nxt = CMD;
            end
            CMD: begin
                if (spi_rxdy) begin
                    if (spi_data_o[6:4] != 3'b000) begin
                        err_nxt   = 1'b1;
                        data_nxt  = 8'hFF;
                        state_nxt = DROP;
                    end else if (spi_data_o[7]) begin
                        addr_nxt  = cmd_addr;
                        state_nxt = WR;
                    end else begin
                        data_nxt  = reg_q[{cmd_addr, 3'b000} +: 8];
                        addr_nxt  = cmd_addr + 4'd1;
                        state_nxt = RD;
                    end
                end
            end
            WR: begin
                if (spi_rxdy) begin
                    data_nxt = spi_data_o;
                    addr_nxt = addr + 4'd1;
                    if (addr != 4'hF) begin
                        wr_nxt      = 1'b1;
                        wr_addr_nxt = addr;
                        wr_data_nxt = spi_data_o;
                    end
                end
            end
            RD: begin
                if (spi_rxdy) begin
                    data_nxt = reg_q[{addr, 3'b000} +: 8];
                    addr_nxt = addr + 4'd1;
                end
            end
            DROP: begin
                data_nxt = 8'hFF;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Frame end wins over state, but a byte arriving in the same cycle
        // has already been processed above (its write still commits).
        if (ssel_s2) begin
            state_nxt = IDLE;
            data_nxt  = 8'h00;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            addr        <= 4'h0;
            spi_data_i  <= 8'h00;
            reg_wr      <= 1'b0;
            reg_wr_addr <= 4'h0;
            reg_wr_data <= 8'h00;
            frame_err   <= 1'b0;
        end else begin
            state       <= state_nxt;
            addr        <= addr_nxt;
            spi_data_i  <= data_nxt;
            reg_wr      <= wr_nxt;
            reg_wr_addr <= wr_addr_nxt;
            reg_wr_data <= wr_data_nxt;
            frame_err   <= err_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 15; i++)
                bank[i] <= 8'h00;
        end else begin
            for (int i = 0; i < 15; i++)
                if (wr_nxt && wr_addr_nxt == 4'(i))
                    bank[i] <= wr_data_nxt;
        end
    end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Scoreboard bench for spi_reg_bridge: stimulus queues expected echo/read bytes and writes.
module tb_spi_reg_bridge;

    logic         clk = 1'b0;
    logic         rst;
    logic         SSEL;
    logic [7:0]   spi_data_o;
    logic         spi_rxdy;
    logic [7:0]   spi_data_i;
    logic         reg_wr;
    logic [3:0]   reg_wr_addr;
    logic [7:0]   reg_wr_data;
    logic [127:0] reg_q;
    logic         frame_err;

    int tests = 0;
    int fails = 0;

    logic [7:0]  data_q [$];
    logic [11:0] wr_q [$];
    int          err_exp = 0;

    spi_reg_bridge #(.ID_VAL(8'hA5)) dut (
        .clk(clk), .rst(rst), .SSEL(SSEL),
        .spi_data_o(spi_data_o), .spi_rxdy(spi_rxdy), .spi_data_i(spi_data_i),
        .reg_wr(reg_wr), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
        .reg_q(reg_q), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic flag(input string nm);
        tests++;
        fails++;
        $display("FAIL %s: unexpected event at %0t", nm, $time);
    endtask

    // Every task starts and ends just after a falling edge.
    task automatic send(input logic [7:0] b, input logic [7:0] exp_dat);
        spi_data_o = b;
        spi_rxdy   = 1'b1;
        data_q.push_back(exp_dat);
        @(negedge clk);
        spi_rxdy = 1'b0;
    endtask

    task automatic exp_wr(input logic [3:0] a, input logic [7:0] d);
        wr_q.push_back({a, d});
    endtask

    task automatic ssel_lo();
        SSEL = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic ssel_hi();
        SSEL = 1'b1;
        repeat (3) @(negedge clk);
        chk("data_after_frame_end", 128'(spi_data_i), 128'h00);
    endtask

    // Monitor: pops expectations whenever the DUT presents a response.
    initial begin
        logic        rx;
        logic [11:0] e;
        forever begin
            @(posedge clk);
            rx = spi_rxdy;
            @(negedge clk);
            if (rx) begin
                if (data_q.size() == 0) flag("data_q_empty");
                else chk("spi_data_i", 128'(spi_data_i), 128'(data_q.pop_front()));
            end
            if (reg_wr) begin
                if (wr_q.size() == 0) flag("reg_wr_unexpected");
                else begin
                    e = wr_q.pop_front();
                    chk("reg_wr_addr", 128'(reg_wr_addr), 128'(e[11:8]));
                    chk("reg_wr_data", 128'(reg_wr_data), 128'(e[7:0]));
                end
            end
            if (frame_err) begin
                if (err_exp == 0) flag("frame_err_unexpected");
                else err_exp--;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; SSEL = 1'b1; spi_data_o = 8'h00; spi_rxdy = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_data_i", 128'(spi_data_i), 128'h00);
        chk("rst_reg_wr", 128'(reg_wr), 128'h0);
        chk("rst_wr_addr", 128'(reg_wr_addr), 128'h0);
        chk("rst_wr_data", 128'(reg_wr_data), 128'h0);
        chk("rst_frame_err", 128'(frame_err), 128'h0);
        chk("rst_reg_q", reg_q, {8'hA5, 120'h0});
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Burst write at 3
        ssel_lo();
        send(8'h83, 8'h00);
        exp_wr(4'h3, 8'h11); send(8'h11, 8'h11);
        exp_wr(4'h4, 8'h22); send(8'h22, 8'h22);
        ssel_hi();
        chk("reg3", 128'(reg_q[31:24]), 128'h11);
        chk("reg4", 128'(reg_q[39:32]), 128'h22);

        // Burst read from 3, back-to-back bytes
        ssel_lo();
        send(8'h03, 8'h11);
        send(8'h5A, 8'h22);
        send(8'h00, 8'h00);
        send(8'hFF, 8'h00);
        ssel_hi();

        // Wrap through protected 0xF
        ssel_lo();
        send(8'h8E, 8'h00);
        exp_wr(4'hE, 8'hAA); send(8'hAA, 8'hAA);
        send(8'hBB, 8'hBB);
        exp_wr(4'h0, 8'hCC); send(8'hCC, 8'hCC);
        ssel_hi();
        chk("regE", 128'(reg_q[119:112]), 128'hAA);
        chk("reg0", 128'(reg_q[7:0]), 128'hCC);
        chk("regF", 128'(reg_q[127:120]), 128'hA5);

        // Illegal command, then a legal frame
        ssel_lo();
        err_exp++; send(8'h40, 8'hFF);
        send(8'h55, 8'hFF);
        @(negedge clk);
        chk("drop_hold_ff", 128'(spi_data_i), 128'hFF);
        ssel_hi();
        ssel_lo();
        send(8'h81, 8'h00);
        exp_wr(4'h1, 8'h5A); send(8'h5A, 8'h5A);
        ssel_hi();
        chk("reg1", 128'(reg_q[15:8]), 128'h5A);

        // Byte coincident with synchronized SSEL rise
        ssel_lo();
        send(8'h87, 8'h00);
        exp_wr(4'h7, 8'h66); send(8'h66, 8'h66);
        SSEL = 1'b1;
        repeat (2) @(negedge clk);
        exp_wr(4'h8, 8'h77); send(8'h77, 8'h00);
        send(8'h99, 8'h00);
        repeat (2) @(negedge clk);
        chk("reg7", 128'(reg_q[63:56]), 128'h66);
        chk("reg8", 128'(reg_q[71:64]), 128'h77);
        chk("reg9", 128'(reg_q[79:72]), 128'h00);

        // Reset mid write frame
        ssel_lo();
        send(8'h85, 8'h00);
        exp_wr(4'h5, 8'h31); send(8'h31, 8'h31);
        rst = 1'b1;
        #1;
        chk("midrst_reg_q", reg_q, {8'hA5, 120'h0});
        chk("midrst_data_i", 128'(spi_data_i), 128'h00);
        chk("midrst_wr_data", 128'(reg_wr_data), 128'h00);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        send(8'h82, 8'h00);
        send(8'h44, 8'h00);
        ssel_hi();
        ssel_lo();
        send(8'h82, 8'h00);
        exp_wr(4'h2, 8'h44); send(8'h44, 8'h44);
        ssel_hi();
        chk("reg2", 128'(reg_q[23:16]), 128'h44);

        repeat (3) @(negedge clk);
        chk("data_q_drained", 128'(data_q.size()), 128'h0);
        chk("wr_q_drained", 128'(wr_q.size()), 128'h0);
        chk("frame_err_seen", 128'(err_exp), 128'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
